// File: rtl/module_ula_seq.sv
// Sequential Mini-CPU ALU: eight-opcode datapath with a start/done handshake
// and an IMM_W-cycle shift-add multiplier for MUL.
module module_ula_seq #(
  parameter int WIDTH = 16,
  parameter int IMM_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic             sinalImm,
  input  logic [IMM_W-1:0] Imm,
  input  logic [WIDTH-1:0] v1ULA,
  input  logic [WIDTH-1:0] v2ULA,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] valorGuardarULA,
  output logic             escrever,
  output logic             zero,
  output logic             overflow
);

  localparam int ACC_W = WIDTH + IMM_W;
  localparam int CNT_W = $clog2(IMM_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(IMM_W - 1);
  localparam logic [ACC_W-1:0] POS_MAX  = (ACC_W'(1) << (WIDTH - 1)) - ACC_W'(1);
  localparam logic [ACC_W-1:0] NEG_MAX  = ACC_W'(1) << (WIDTH - 1);

  localparam logic [2:0] OP_LOAD    = 3'd0;
  localparam logic [2:0] OP_ADD     = 3'd1;
  localparam logic [2:0] OP_ADDI    = 3'd2;
  localparam logic [2:0] OP_SUB     = 3'd3;
  localparam logic [2:0] OP_SUBI    = 3'd4;
  localparam logic [2:0] OP_MUL     = 3'd5;
  localparam logic [2:0] OP_CLEAR   = 3'd6;
  localparam logic [2:0] OP_DISPLAY = 3'd7;

  typedef enum logic [1:0] {IDLE, MUL_RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] mag_q;
  logic [IMM_W-1:0] imm_q;
  logic             neg_q;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] imm_ext, imm_s, operand_b, b_eff, sum, alu_res, v1_abs;
  logic             is_sub, arith_ovf, alu_ovf;
  logic [ACC_W-1:0] acc_next;
  logic             mul_neg, mul_ovf;
  logic [WIDTH-1:0] mul_res;

  // Single-cycle opcodes are evaluated straight from the inputs, since their
  // result registers on the same edge that samples start.
  always_comb begin
    imm_ext   = {{(WIDTH-IMM_W){1'b0}}, Imm};
    imm_s     = sinalImm ? -imm_ext : imm_ext;
    operand_b = (opcode == OP_ADDI || opcode == OP_SUBI) ? imm_s : v2ULA;
    is_sub    = (opcode == OP_SUB || opcode == OP_SUBI);
    b_eff     = is_sub ? -operand_b : operand_b;
    sum       = v1ULA + b_eff;
    arith_ovf = (v1ULA[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != v1ULA[WIDTH-1]);
    v1_abs    = v1ULA[WIDTH-1] ? -v1ULA : v1ULA;
    alu_res   = '0;
    alu_ovf   = 1'b0;
    case (opcode)
      OP_LOAD: alu_res = imm_s;
      OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
        alu_res = sum;
        alu_ovf = arith_ovf;
      end
      default: begin
        alu_res = '0;
        alu_ovf = 1'b0;
      end
    endcase
  end

  // One shift-add step per cycle; the last step's sum feeds the final result.
  always_comb begin
    acc_next = acc;
    if (imm_q[cnt])
      acc_next = acc + ({{IMM_W{1'b0}}, mag_q} << cnt);
    mul_neg = neg_q && (acc_next != '0);
    mul_res = mul_neg ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
    mul_ovf = mul_neg ? (acc_next > NEG_MAX) : (acc_next > POS_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      escrever        <= 1'b0;
      valorGuardarULA <= '0;
      zero            <= 1'b0;
      overflow        <= 1'b0;
      acc             <= '0;
      cnt             <= '0;
      mag_q           <= '0;
      imm_q           <= '0;
      neg_q           <= 1'b0;
    end else begin
      done     <= 1'b0;
      escrever <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (opcode == OP_MUL) begin
              state <= MUL_RUN;
              acc   <= '0;
              cnt   <= '0;
              mag_q <= v1_abs;
              imm_q <= Imm;
              neg_q <= v1ULA[WIDTH-1] ^ sinalImm;
            end else begin
              state <= DONE;
              done  <= 1'b1;
              // DISPLAY reports completion but leaves the result and flags untouched
              if (opcode != OP_DISPLAY) begin
                escrever        <= 1'b1;
                valorGuardarULA <= alu_res;
                zero            <= (alu_res == '0);
                overflow        <= alu_ovf;
              end
            end
          end
        end
        MUL_RUN: begin
          acc <= acc_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            state           <= DONE;
            done            <= 1'b1;
            escrever        <= 1'b1;
            valorGuardarULA <= mul_res;
            zero            <= (mul_res == '0);
            overflow        <= mul_ovf;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_module_ula_seq.sv
// Directed self-checking bench for module_ula_seq with hand-computed vectors.
module tb_module_ula_seq;

  localparam int WIDTH = 16;
  localparam int IMM_W = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [2:0]       opcode = 3'd0;
  logic             sinalImm = 1'b0;
  logic [IMM_W-1:0] Imm = '0;
  logic [WIDTH-1:0] v1ULA = '0;
  logic [WIDTH-1:0] v2ULA = '0;
  logic             busy, done, escrever, zero, overflow;
  logic [WIDTH-1:0] valorGuardarULA;

  int vectors = 0;
  int miscompares = 0;

  module_ula_seq #(.WIDTH(WIDTH), .IMM_W(IMM_W)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .sinalImm(sinalImm),
    .Imm(Imm), .v1ULA(v1ULA), .v2ULA(v2ULA), .busy(busy), .done(done),
    .valorGuardarULA(valorGuardarULA), .escrever(escrever), .zero(zero),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one request and returns in cycle 1 (#1 after the sampling edge).
  task automatic applyStimulus(input logic [2:0] op, input logic s,
                               input logic [IMM_W-1:0] imm,
                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    opcode = op; sinalImm = s; Imm = imm; v1ULA = a; v2ULA = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge clk); #1;
  endtask

  // Steps forward until done, bounded; returns the cycle index it was seen in.
  task automatic waitDone(input string tag, output int cycle);
    cycle = 1;
    while (!done && cycle < 20) begin
      nextCycle();
      cycle++;
    end
    if (!done) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic checkResult(input string tag, input logic [WIDTH-1:0] res,
                             input logic wr, input logic z, input logic ovf);
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_res"}, 32'(valorGuardarULA), 32'(res));
    checkOutput({tag, "_wr"}, 32'(escrever), 32'(wr));
    checkOutput({tag, "_zero"}, 32'(zero), 32'(z));
    checkOutput({tag, "_ovf"}, 32'(overflow), 32'(ovf));
  endtask

  task automatic checkIdle(input string tag);
    nextCycle();
    checkOutput({tag, "_done_low"}, 32'(done), 32'd0);
    checkOutput({tag, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    rst = 1'b1;
    start = 1'b1;
    repeat (2) nextCycle();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_wr", 32'(escrever), 32'd0);
    checkOutput("rst_res", 32'(valorGuardarULA), 32'd0);
    checkOutput("rst_zero", 32'(zero), 32'd0);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);
    start = 1'b0;
    @(negedge clk); rst = 1'b0;

    applyStimulus(3'd0, 1'b1, 6'd5, 16'h0000, 16'h0000);
    checkOutput("load_busy", 32'(busy), 32'd1);
    checkResult("load", 16'hFFFB, 1'b1, 1'b0, 1'b0);
    checkIdle("load");

    applyStimulus(3'd1, 1'b0, 6'd0, 16'h7FFF, 16'h0001);
    checkResult("add_ovf", 16'h8000, 1'b1, 1'b0, 1'b1);
    checkIdle("add_ovf");

    applyStimulus(3'd3, 1'b0, 6'd0, 16'd5, 16'd5);
    checkResult("sub_zero", 16'h0000, 1'b1, 1'b1, 1'b0);
    checkIdle("sub_zero");

    applyStimulus(3'd4, 1'b1, 6'd3, 16'd10, 16'd0);
    checkResult("subi", 16'd13, 1'b1, 1'b0, 1'b0);
    checkIdle("subi");

    applyStimulus(3'd2, 1'b1, 6'd7, 16'd4, 16'd0);
    checkResult("addi", 16'hFFFD, 1'b1, 1'b0, 1'b0);
    checkIdle("addi");

    // MUL -3 * 63 with an ignored ADD request in cycle 3
    applyStimulus(3'd5, 1'b0, 6'd63, 16'hFFFD, 16'h0000);
    for (int c = 1; c <= 9; c++) begin
      checkOutput($sformatf("mul_done_c%0d", c), 32'(done), 32'(c == 7));
      checkOutput($sformatf("mul_busy_c%0d", c), 32'(busy), 32'(c <= 7));
      if (c == 7) checkResult("mul_neg", 16'hFF43, 1'b1, 1'b0, 1'b0);
      if (c == 3) begin
        start = 1'b1; opcode = 3'd1; v1ULA = 16'd1; v2ULA = 16'd1; Imm = 6'd0;
      end else begin
        start = 1'b0;
      end
      nextCycle();
    end

    applyStimulus(3'd5, 1'b0, 6'd4, 16'h4000, 16'h0000);
    waitDone("mul_wrap", cyc);
    checkOutput("mul_wrap_latency", 32'(cyc), 32'd7);
    checkResult("mul_wrap", 16'h0000, 1'b1, 1'b1, 1'b1);
    checkIdle("mul_wrap");

    applyStimulus(3'd5, 1'b0, 6'd2, 16'hC000, 16'h0000);
    waitDone("mul_min", cyc);
    checkResult("mul_min", 16'h8000, 1'b1, 1'b0, 1'b0);
    checkIdle("mul_min");

    applyStimulus(3'd1, 1'b0, 6'd0, 16'd2, 16'd3);
    checkResult("add5", 16'd5, 1'b1, 1'b0, 1'b0);
    checkIdle("add5");
    applyStimulus(3'd7, 1'b0, 6'd0, 16'd9, 16'd9);
    checkResult("display", 16'd5, 1'b0, 1'b0, 1'b0);
    checkIdle("display");
    applyStimulus(3'd6, 1'b0, 6'd0, 16'd9, 16'd9);
    checkResult("clear", 16'd0, 1'b1, 1'b1, 1'b0);
    checkIdle("clear");

    // Reset in cycle 3 of a MUL aborts it
    applyStimulus(3'd5, 1'b1, 6'd9, 16'd7, 16'd0);
    nextCycle();
    nextCycle();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_res", 32'(valorGuardarULA), 32'd0);
    checkOutput("abort_wr", 32'(escrever), 32'd0);
    for (int c = 5; c <= 12; c++) begin
      nextCycle();
      checkOutput($sformatf("abort_nodone_c%0d", c), 32'(done), 32'd0);
    end
    applyStimulus(3'd1, 1'b0, 6'd0, 16'd1, 16'd1);
    checkResult("post_abort_add", 16'd2, 1'b1, 1'b0, 1'b0);
    checkIdle("post_abort_add");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
